ift_sram_bank_ctrl: RTL and testbench
=====================================

Name: ift_sram_bank_ctrl

Overview:
Upstream request stage for one interleaved ift_sram bank.
- Accepts taint-carrying req/gnt/rvalid/rready bus requests with 32-bit byte addresses.
- Maps each address to a bank-local word address and drives the SRAM ports.
- Queues SRAM read data and write acks in a small response FIFO that the consumer drains with backpressure.
- Propagates NumTaints taint bits alongside every signal.

Parameters:
NumWords, 1024, words in the attached bank
DataWidth, 128, data width
ByteWidth, 8, bits per byte
NumBanks, 8, interleave factor (power of 2)
BankId, 0, this bank's index
AddrOffset, 32'h1C000000, base of the interleaved region
NumTaints, 1, taint bit-planes (must be 1)
RespDepth, 2, response FIFO entries (>=2)
AddrWidth, $clog2(NumWords), derived, do not override
WidthBytes, ceil(DataWidth/ByteWidth), derived, do not override

Ports:
clk_i  in  1  clock, single domain
rst_i  in  1  synchronous, active-high reset
req_i  in  1  request valid
gnt_o  out  1  request accepted this cycle
we_i  in  1  write enable
addr_i  in  32  byte address
wdata_i  in  DataWidth  write data
be_i  in  WidthBytes  byte enables
rvalid_o  out  1  response valid
rready_i  in  1  response consumed
rdata_o  out  DataWidth  read data (0 for writes/errors)
err_o  out  1  response error
sram_req_o, sram_we_o, sram_addr_o[AddrWidth], sram_wdata_o, sram_be_o  out  to bank
sram_rdata_i  in  DataWidth  from bank, valid the cycle after sram_req_o
*_t0  in/out  [NumTaints][width of base]  taint for every port above, except clk_i and rst_i, which have no taint port

Behaviour:
- Reset (rst_i=1 at a posedge): clears the in-flight register, the FIFO and all taint state. Outputs are then gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, sram_req_o=0, and all *_t0 outputs are 0.
- Reset mid-operation: drops any in-flight SRAM response.
- Address mapping: w = (addr_i - AddrOffset) >> log2(WidthBytes); bank = w mod NumBanks; sram_addr_o = (w / NumBanks) truncated to AddrWidth. Subtraction wraps modulo 2^32.
- Credit rule: gnt_o = req_i & (inflight + fifo_count < RespDepth). Credits are counted conservatively, so a same-cycle pop does not free a credit.
- Hit condition: hit = (bank == BankId).
- SRAM drive: sram_req_o = req_i & gnt_o & hit. we, wdata and be pass straight through.
- In-flight register: on a grant, latches {we, err = ~hit, addr_taint, req_taint}.
- Response forming, cycle N+1 after a grant at N:
  - hit read: rdata = sram_rdata_i;
  - write: rdata = 0, err = 0;
  - miss: rdata = 0, err = 1, and the SRAM is never accessed.
- Response path: if the FIFO is empty, the entry bypasses onto the outputs at N+1 (1-cycle min latency); if rready_i is also high it is consumed and not stored; otherwise it is pushed. Outputs show the FIFO head.
- Ordering: strict FIFO. Pointers wrap modulo RespDepth. Push and pop in the same cycle leave the count unchanged.
- Full FIFO: gnt_o stays 0 until an entry pops. Data is never dropped.
- Taint rules:
  - req_taint = req_i_t0 | (req_i & we_i_t0);
  - addr_taint = |addr_i_t0;
  - gnt_o_t0 = req_i_t0;
  - sram_addr_o_t0 = all ones if addr_taint, else 0;
  - sram_wdata/be/we/req taints are forwarded from the corresponding inputs;
  - rdata_o_t0 = sram_rdata_i_t0 | all ones if (addr_taint | req_taint);
  - err_o_t0 = addr_taint;
  - rvalid_o_t0 = req_taint.
  - Taints travel through the FIFO with their data.

Optional Feature:
IFT_SRAM_BANK_CTRL_RANGE_CHECK_EN.
- Defined: addresses outside [AddrOffset, AddrOffset + NumWords*NumBanks*WidthBytes) are also misses and return err_o=1.
- Undefined: only the bank-select comparison applies, upper bits alias, and out-of-window addresses still access the bank.

Decomposition:
- Shared package ift_sram_pkg holds:
  - resp_entry_t {rdata, err, rdata_t, err_t, rvalid_t};
  - the addr->(bank, local word) mapping function;
  - a localparam for the byte-offset bit count.
- Sub-module ift_resp_fifo: generic depth-parameterised FIFO with a bypass port.

Test Plan:
1. Read hit at BankId=0, addr 0x1C000000 preloaded with 0xA5.. -> gnt_o same cycle; rvalid_o next cycle, rdata_o=0xA5.., err_o=0.
2. Addr 0x1C000010 (bank 1, not this bank) -> sram_req_o=0; rvalid_o next cycle with err_o=1, rdata_o=0.
3. rready_i=0, three back-to-back reads -> two grants, third held until one pop; responses come out in order.
4. Write with be=0x0001 then read of the same word -> write ack rdata_o=0; read returns only byte 0 updated.
5. Read with addr_i_t0[4]=1 -> sram_addr_o_t0 all ones; rdata_o_t0 all ones; err_o_t0=1.
6. rst_i asserted the cycle after a grant -> no rvalid_o; gnt_o=0 and all outputs 0 the following cycle.

Source files
------------

// File: rtl/ift_sram_pkg.sv
// Shared types and helpers for the ift_sram bank controller: the response
// FIFO entry layout, the byte-offset width and the interleaved address map.
package ift_sram_pkg;

  // Response data width carried through the FIFO; the bank controller's
  // DataWidth must match it.
  localparam int unsigned RESP_DATA_W = 128;
  localparam int unsigned RESP_BYTE_W = 8;

  // Number of byte-offset bits stripped from a byte address to get a word index.
  localparam int unsigned BYTE_OFF_BITS = $clog2((RESP_DATA_W + RESP_BYTE_W - 1) / RESP_BYTE_W);

  // One queued response plus the taint that travels with it.
  typedef struct packed {
    logic [RESP_DATA_W-1:0] rdata;
    logic                   err;
    logic [RESP_DATA_W-1:0] rdata_t;
    logic                   err_t;
    logic                   rvalid_t;
  } resp_entry_t;

  // Result of the interleave map: bank select and bank-local word index.
  typedef struct packed {
    logic [31:0] bank;
    logic [31:0] word;
  } addr_map_t;

  // Byte address -> (bank, local word). The subtraction wraps modulo 2^32.
  function automatic addr_map_t map_addr(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned off_bits,
    input int unsigned bank_bits
  );
    logic [31:0] w_idx;
    addr_map_t   m;
    w_idx  = (addr - base) >> off_bits;
    m.bank = w_idx & ((32'd1 << bank_bits) - 32'd1);
    m.word = w_idx >> bank_bits;
    return m;
  endfunction

endpackage

// File: rtl/ift_resp_fifo.sv
// Depth-parameterised response FIFO with a bypass path: when empty, the
// incoming entry is presented on the output in the same cycle and is only
// stored if the consumer does not take it.
module ift_resp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  input  logic [Width-1:0] i_in_data,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic [Width-1:0] o_out_data,
  output logic [CntW-1:0]  o_count
);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;

  logic w_empty;
  logic w_store;
  logic w_pop_mem;

  assign w_empty     = (r_count == '0);
  assign o_out_valid = ~w_empty | i_in_valid;
  assign o_out_data  = ~w_empty ? r_mem[r_rd_ptr] : (i_in_valid ? i_in_data : '0);
  assign o_count     = r_count;

  // An entry is stored unless it bypasses straight into a ready consumer.
  assign w_store   = i_in_valid & ~(w_empty & i_out_ready);
  assign w_pop_mem = ~w_empty & i_out_ready;

  // Entry storage; cleared on reset so no stale taint survives.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_store) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  // Pointers wrap modulo Depth; simultaneous push and pop keep the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop_mem) begin
        r_rd_ptr <= (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CntW'(w_store) - CntW'(w_pop_mem);
    end
  end

endmodule

// File: rtl/ift_sram_bank_ctrl.sv
// Request stage for one interleaved ift_sram bank with information-flow
// taint tracking. Optional macro IFT_SRAM_BANK_CTRL_RANGE_CHECK_EN turns
// addresses outside the interleaved window into error responses.
module ift_sram_bank_ctrl
  import ift_sram_pkg::*;
#(
  parameter int unsigned NumWords   = 1024,
  parameter int unsigned DataWidth  = 128,
  parameter int unsigned ByteWidth  = 8,
  parameter int unsigned NumBanks   = 8,
  parameter int unsigned BankId     = 0,
  parameter logic [31:0] AddrOffset = 32'h1C000000,
  parameter int unsigned NumTaints  = 1,
  parameter int unsigned RespDepth  = 2,
  localparam int unsigned AddrWidth  = $clog2(NumWords),
  localparam int unsigned WidthBytes = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 req_i,
  input  logic [NumTaints-1:0]                 req_i_t0,
  output logic                                 gnt_o,
  output logic [NumTaints-1:0]                 gnt_o_t0,
  input  logic                                 we_i,
  input  logic [NumTaints-1:0]                 we_i_t0,
  input  logic [31:0]                          addr_i,
  input  logic [NumTaints-1:0][31:0]           addr_i_t0,
  input  logic [DataWidth-1:0]                 wdata_i,
  input  logic [NumTaints-1:0][DataWidth-1:0]  wdata_i_t0,
  input  logic [WidthBytes-1:0]                be_i,
  input  logic [NumTaints-1:0][WidthBytes-1:0] be_i_t0,
  output logic                                 rvalid_o,
  output logic [NumTaints-1:0]                 rvalid_o_t0,
  input  logic                                 rready_i,
  input  logic [NumTaints-1:0]                 rready_i_t0,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic [NumTaints-1:0][DataWidth-1:0]  rdata_o_t0,
  output logic                                 err_o,
  output logic [NumTaints-1:0]                 err_o_t0,
  output logic                                 sram_req_o,
  output logic [NumTaints-1:0]                 sram_req_o_t0,
  output logic                                 sram_we_o,
  output logic [NumTaints-1:0]                 sram_we_o_t0,
  output logic [AddrWidth-1:0]                 sram_addr_o,
  output logic [NumTaints-1:0][AddrWidth-1:0]  sram_addr_o_t0,
  output logic [DataWidth-1:0]                 sram_wdata_o,
  output logic [NumTaints-1:0][DataWidth-1:0]  sram_wdata_o_t0,
  output logic [WidthBytes-1:0]                sram_be_o,
  output logic [NumTaints-1:0][WidthBytes-1:0] sram_be_o_t0,
  input  logic [DataWidth-1:0]                 sram_rdata_i,
  input  logic [NumTaints-1:0][DataWidth-1:0]  sram_rdata_i_t0
);

  localparam int unsigned BankBits = $clog2(NumBanks);
  localparam int unsigned CntW     = $clog2(RespDepth + 1);

  // In-flight request (granted last cycle, response due this cycle).
  logic r_inf_valid;
  logic r_inf_we;
  logic r_inf_err;
  logic r_inf_addr_t;
  logic r_inf_req_t;

  addr_map_t   w_map;
  logic        w_hit;
  logic        w_credit;
  logic        w_req_t;
  logic        w_addr_t;
  logic        w_hit_read;
  logic [CntW-1:0] w_fifo_count;
  logic [CntW:0]   w_used;
  logic        w_fifo_valid;
  resp_entry_t w_resp;
  resp_entry_t w_head;
  logic        w_unused;

  assign w_map = map_addr(addr_i, AddrOffset, BYTE_OFF_BITS, BankBits);

`ifdef IFT_SRAM_BANK_CTRL_RANGE_CHECK_EN
  localparam logic [32:0] WindowBytes = 33'(NumWords) * 33'(NumBanks) * 33'(WidthBytes);
  logic [31:0] w_offset;
  assign w_offset = addr_i - AddrOffset;
  assign w_hit    = (w_map.bank == 32'(BankId)) && ({1'b0, w_offset} < WindowBytes);
`else
  // Upper address bits alias: only the bank select decides a hit.
  assign w_hit = (w_map.bank == 32'(BankId));
`endif

  // Credits count the in-flight slot plus stored entries; a same-cycle pop
  // is deliberately not credited back, keeping the grant path short.
  assign w_used   = {1'b0, w_fifo_count} + {{CntW{1'b0}}, r_inf_valid};
  assign w_credit = (w_used < (CntW + 1)'(RespDepth));

  assign gnt_o       = req_i & w_credit & ~rst_i;
  assign sram_req_o  = req_i & gnt_o & w_hit;
  assign sram_we_o   = we_i;
  assign sram_addr_o = w_map.word[AddrWidth-1:0];
  assign sram_wdata_o = wdata_i;
  assign sram_be_o   = be_i;

  // Taint of the request itself and of the address it carries.
  assign w_req_t  = req_i_t0[0] | (req_i & we_i_t0[0]);
  assign w_addr_t = |addr_i_t0[0];

  assign gnt_o_t0        = req_i_t0;
  assign sram_req_o_t0   = req_i_t0;
  assign sram_we_o_t0    = we_i_t0;
  assign sram_wdata_o_t0 = wdata_i_t0;
  assign sram_be_o_t0    = be_i_t0;
  assign sram_addr_o_t0[0] = {AddrWidth{w_addr_t}};

  // Latch what the response needs to know about each granted request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inf_valid  <= 1'b0;
      r_inf_we     <= 1'b0;
      r_inf_err    <= 1'b0;
      r_inf_addr_t <= 1'b0;
      r_inf_req_t  <= 1'b0;
    end else begin
      r_inf_valid <= gnt_o;
      if (gnt_o) begin
        r_inf_we     <= we_i;
        r_inf_err    <= ~w_hit;
        r_inf_addr_t <= w_addr_t;
        r_inf_req_t  <= w_req_t;
      end
    end
  end

  assign w_hit_read = r_inf_valid & ~r_inf_we & ~r_inf_err;

  // Form the response entry; only hit reads carry SRAM data and its taint.
  always_comb begin
    w_resp          = '0;
    w_resp.rdata    = w_hit_read ? sram_rdata_i : '0;
    w_resp.err      = r_inf_err;
    w_resp.rdata_t  = (w_hit_read ? sram_rdata_i_t0[0] : '0)
                    | {DataWidth{r_inf_addr_t | r_inf_req_t}};
    w_resp.err_t    = r_inf_addr_t;
    w_resp.rvalid_t = r_inf_req_t;
  end

  ift_resp_fifo #(
    .Width($bits(resp_entry_t)),
    .Depth(RespDepth)
  ) u_resp_fifo (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_in_valid (r_inf_valid),
    .i_in_data  (w_resp),
    .i_out_ready(rready_i),
    .o_out_valid(w_fifo_valid),
    .o_out_data (w_head),
    .o_count    (w_fifo_count)
  );

  // A response due while reset is held is dropped, never shown.
  assign rvalid_o      = w_fifo_valid & ~rst_i;
  assign rdata_o       = w_head.rdata;
  assign err_o         = w_head.err;
  assign rdata_o_t0[0] = w_head.rdata_t;
  assign err_o_t0[0]   = w_head.err_t;
  assign rvalid_o_t0[0] = w_head.rvalid_t;

  assign w_unused = ^{rready_i_t0, w_map.word[31:AddrWidth]};

endmodule

// File: tb/tb_ift_sram_bank_ctrl.sv
// Directed bench for ift_sram_bank_ctrl with a behavioural bank model.
module tb_ift_sram_bank_ctrl;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               req_i;
  logic [0:0]         req_i_t0;
  logic               gnt_o;
  logic [0:0]         gnt_o_t0;
  logic               we_i;
  logic [0:0]         we_i_t0;
  logic [31:0]        addr_i;
  logic [0:0][31:0]   addr_i_t0;
  logic [127:0]       wdata_i;
  logic [0:0][127:0]  wdata_i_t0;
  logic [15:0]        be_i;
  logic [0:0][15:0]   be_i_t0;
  logic               rvalid_o;
  logic [0:0]         rvalid_o_t0;
  logic               rready_i;
  logic [0:0]         rready_i_t0;
  logic [127:0]       rdata_o;
  logic [0:0][127:0]  rdata_o_t0;
  logic               err_o;
  logic [0:0]         err_o_t0;
  logic               sram_req_o;
  logic [0:0]         sram_req_o_t0;
  logic               sram_we_o;
  logic [0:0]         sram_we_o_t0;
  logic [9:0]         sram_addr_o;
  logic [0:0][9:0]    sram_addr_o_t0;
  logic [127:0]       sram_wdata_o;
  logic [0:0][127:0]  sram_wdata_o_t0;
  logic [15:0]        sram_be_o;
  logic [0:0][15:0]   sram_be_o_t0;
  logic [127:0]       sram_rdata_i;
  logic [0:0][127:0]  sram_rdata_i_t0;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] PAT_A = {16{8'hA5}};
  localparam logic [127:0] PAT_B = {8{16'hB00B}};
  localparam logic [127:0] PAT_C = {4{32'hC0FFEE00}};
  localparam logic [127:0] PAT_D = {16{8'h5A}};
  localparam logic [127:0] ONES  = {128{1'b1}};

  ift_sram_bank_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_i), .req_i_t0(req_i_t0),
    .gnt_o(gnt_o), .gnt_o_t0(gnt_o_t0),
    .we_i(we_i), .we_i_t0(we_i_t0),
    .addr_i(addr_i), .addr_i_t0(addr_i_t0),
    .wdata_i(wdata_i), .wdata_i_t0(wdata_i_t0),
    .be_i(be_i), .be_i_t0(be_i_t0),
    .rvalid_o(rvalid_o), .rvalid_o_t0(rvalid_o_t0),
    .rready_i(rready_i), .rready_i_t0(rready_i_t0),
    .rdata_o(rdata_o), .rdata_o_t0(rdata_o_t0),
    .err_o(err_o), .err_o_t0(err_o_t0),
    .sram_req_o(sram_req_o), .sram_req_o_t0(sram_req_o_t0),
    .sram_we_o(sram_we_o), .sram_we_o_t0(sram_we_o_t0),
    .sram_addr_o(sram_addr_o), .sram_addr_o_t0(sram_addr_o_t0),
    .sram_wdata_o(sram_wdata_o), .sram_wdata_o_t0(sram_wdata_o_t0),
    .sram_be_o(sram_be_o), .sram_be_o_t0(sram_be_o_t0),
    .sram_rdata_i(sram_rdata_i), .sram_rdata_i_t0(sram_rdata_i_t0)
  );

  always #5 clk_i = ~clk_i;

  assign sram_rdata_i_t0 = '0;

  // Behavioural bank: registered read, byte-enabled write, preloaded on reset.
  logic [127:0] mem [1024];
  always @(posedge clk_i) begin
    if (rst_i) begin
      mem[0] <= PAT_A;
      mem[1] <= PAT_B;
      mem[2] <= PAT_C;
      mem[3] <= PAT_D;
      sram_rdata_i <= '0;
    end else if (sram_req_o) begin
      if (sram_we_o) begin
        for (int i = 0; i < 16; i++) begin
          if (sram_be_o[i]) mem[sram_addr_o][i*8 +: 8] <= sram_wdata_o[i*8 +: 8];
        end
      end else begin
        sram_rdata_i <= mem[sram_addr_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) $display("ok   %-14s = %h", tag, obs);
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well before the next edge.
  task automatic settle();
    #3;
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    rready_i = 1'b0; req_i_t0 = '0; we_i_t0 = '0; addr_i_t0 = '0; wdata_i_t0 = '0;
    be_i_t0 = '0; rready_i_t0 = '0;
    step(); step(); settle();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_sram_req", sram_req_o, 0);
    chk("rst_rdata_t", rdata_o_t0, 0);
    chk("rst_err_t", err_o_t0, 0);
    chk("rst_rvalid_t", rvalid_o_t0, 0);
    step(); rst_i = 1'b0;

    // 1: read hit on local word 0
    step(); req_i = 1; addr_i = 32'h1C000000; rready_i = 1; settle();
    chk("t1_gnt", gnt_o, 1);
    chk("t1_sram_req", sram_req_o, 1);
    chk("t1_sram_addr", sram_addr_o, 0);
    step(); req_i = 0; settle();
    chk("t1_rvalid", rvalid_o, 1);
    chk("t1_rdata", rdata_o, PAT_A);
    chk("t1_err", err_o, 0);
    step(); settle();
    chk("t1_idle", rvalid_o, 0);

    // 2: address in bank 1 is a miss
    step(); req_i = 1; addr_i = 32'h1C000010; settle();
    chk("t2_gnt", gnt_o, 1);
    chk("t2_sram_req", sram_req_o, 0);
    step(); req_i = 0; settle();
    chk("t2_rvalid", rvalid_o, 1);
    chk("t2_err", err_o, 1);
    chk("t2_rdata", rdata_o, 0);

    // 3: backpressure, three back-to-back reads
    step(); rready_i = 0; req_i = 1; addr_i = 32'h1C000000; settle();
    chk("t3_gnt_a", gnt_o, 1);
    step(); addr_i = 32'h1C000080; settle();
    chk("t3_gnt_b", gnt_o, 1);
    chk("t3_head_a0", rdata_o, PAT_A);
    step(); addr_i = 32'h1C000100; settle();
    chk("t3_hold_c0", gnt_o, 0);
    chk("t3_no_sram", sram_req_o, 0);
    chk("t3_rvalid", rvalid_o, 1);
    step(); settle();
    chk("t3_hold_c1", gnt_o, 0);
    step(); rready_i = 1; settle();
    chk("t3_hold_pop", gnt_o, 0);
    chk("t3_head_a1", rdata_o, PAT_A);
    step(); rready_i = 0; settle();
    chk("t3_gnt_c", gnt_o, 1);
    chk("t3_sram_c", sram_req_o, 1);
    chk("t3_head_b0", rdata_o, PAT_B);
    step(); req_i = 0; rready_i = 1; settle();
    chk("t3_head_b1", rdata_o, PAT_B);
    step(); settle();
    chk("t3_rvalid_c", rvalid_o, 1);
    chk("t3_head_c", rdata_o, PAT_C);
    step(); settle();
    chk("t3_drained", rvalid_o, 0);

    // 4: byte-0 write then read back local word 3
    step(); req_i = 1; we_i = 1; addr_i = 32'h1C000180; wdata_i = {16{8'h11}}; be_i = 16'h0001; settle();
    chk("t4_gnt_w", gnt_o, 1);
    chk("t4_sram_addr", sram_addr_o, 3);
    step(); we_i = 0; settle();
    chk("t4_gnt_r", gnt_o, 1);
    chk("t4_ack_valid", rvalid_o, 1);
    chk("t4_ack_rdata", rdata_o, 0);
    chk("t4_ack_err", err_o, 0);
    step(); req_i = 0; settle();
    chk("t4_rd_valid", rvalid_o, 1);
    chk("t4_rd_data", rdata_o, {{15{8'h5A}}, 8'h11});

    // 5: tainted address bit 4
    step(); req_i = 1; addr_i = 32'h1C000000; addr_i_t0 = 32'h10; settle();
    chk("t5_addr_t", sram_addr_o_t0, 10'h3FF);
    chk("t5_gnt_t", gnt_o_t0, 0);
    step(); req_i = 0; addr_i_t0 = '0; settle();
    chk("t5_rdata", rdata_o, PAT_A);
    chk("t5_rdata_t", rdata_o_t0, ONES);
    chk("t5_err_t", err_o_t0, 1);
    chk("t5_rvalid_t", rvalid_o_t0, 0);
    step(); req_i = 1; req_i_t0 = 1; settle();
    chk("t5_gnt_t_req", gnt_o_t0, 1);
    chk("t5_sram_req_t", sram_req_o_t0, 1);
    step(); req_i = 0; req_i_t0 = 0; settle();
    chk("t5_rvalid_t2", rvalid_o_t0, 1);
    chk("t5_rdata_t2", rdata_o_t0, ONES);
    chk("t5_err_t2", err_o_t0, 0);

    // Out-of-window address aliasing back onto local word 0
    step(); req_i = 1; addr_i = 32'h1C020000; settle();
`ifdef IFT_SRAM_BANK_CTRL_RANGE_CHECK_EN
    chk("win_sram_req", sram_req_o, 0);
    step(); req_i = 0; settle();
    chk("win_err", err_o, 1);
    chk("win_rdata", rdata_o, 0);
`else
    chk("win_sram_req", sram_req_o, 1);
    step(); req_i = 0; settle();
    chk("win_err", err_o, 0);
    chk("win_rdata", rdata_o, PAT_A);
`endif

    // 6: reset the cycle after a grant drops the response
    step(); req_i = 1; addr_i = 32'h1C000000; settle();
    chk("t6_gnt", gnt_o, 1);
    step(); req_i = 0; rst_i = 1; settle();
    chk("t6_rvalid_rst", rvalid_o, 0);
    step(); rst_i = 0; settle();
    chk("t6_rvalid", rvalid_o, 0);
    chk("t6_gnt0", gnt_o, 0);
    chk("t6_rdata", rdata_o, 0);
    chk("t6_err", err_o, 0);
    chk("t6_sram_req", sram_req_o, 0);
    chk("t6_rdata_t", rdata_o_t0, 0);
    step(); req_i = 1; addr_i = 32'h1C000080; settle();
    chk("t6_gnt_again", gnt_o, 1);
    step(); req_i = 0; settle();
    chk("t6_rdata_b", rdata_o, PAT_B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
